// File: rtl/pixel_streamer.sv
// rtl/pixel_streamer.sv - streams a stored image from pixel memory to the resizer with eol/eof tags
// Optional internal test pattern source: define PIXEL_STREAMER_TESTPAT_EN.
module pixel_streamer #(
    parameter int img_height = 4,
    parameter int img_width  = 4,
    parameter int addr_width = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
`ifdef PIXEL_STREAMER_TESTPAT_EN
    input  logic                  test_mode,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [addr_width-1:0] mem_addr,
    input  logic [7:0]            mem_data,
    output logic [7:0]            pixel_out,
    output logic                  pixel_valid,
    input  logic                  pixel_ready,
    output logic                  pixel_eol,
    output logic                  pixel_eof
);
    localparam int N  = img_height * img_width;
    localparam int CW = (img_width > 1) ? $clog2(img_width) : 1;
    localparam int RW = (img_height > 1) ? $clog2(img_height) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                r_state, w_next;
    logic [addr_width-1:0] r_addr;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic                  r_inflight, r_in_eol, r_in_eof, r_test;
    logic [7:0]            r_pat;
    logic [7:0]            r_fifo_data [2];
    logic [1:0]            r_fifo_eol, r_fifo_eof;
    logic                  r_wr_ptr, r_rd_ptr;
    logic [1:0]            r_count;

    logic       w_pop, w_issue, w_last, w_start, w_finish, w_test_in;
    logic [2:0] w_credit;
    logic [7:0] w_pat, w_push_data;

`ifdef PIXEL_STREAMER_TESTPAT_EN
    assign w_test_in = test_mode;
`else
    assign w_test_in = 1'b0;
`endif

    assign pixel_valid = (r_count != 2'd0);
    assign w_pop       = pixel_valid & pixel_ready;
    // Reads already committed to the FIFO, net of the pop happening this cycle.
    assign w_credit    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == FETCH) && (w_credit < 3'd2);
    assign w_last      = (r_addr == addr_width'(N - 1));
    assign w_start     = (r_state == IDLE) && start;
    assign w_finish    = (r_state == DRAIN) && (r_count == 2'd0) && !r_inflight;
    assign w_pat       = {4'(r_row), 4'(r_col)};
    assign w_push_data = r_test ? r_pat : mem_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FETCH;
            FETCH:   if (w_issue && w_last) w_next = DRAIN;
            DRAIN:   if (w_finish) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != IDLE) && !w_finish;
        done        = w_finish;
        mem_rd_en   = w_issue && !r_test;
        mem_addr    = r_addr;
        pixel_out   = pixel_valid ? r_fifo_data[r_rd_ptr] : 8'h00;
        pixel_eol   = pixel_valid && r_fifo_eol[r_rd_ptr];
        pixel_eof   = pixel_valid && r_fifo_eof[r_rd_ptr];
    end

    // Address stops at N-1 so mem_addr holds the last issued address until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_test     <= 1'b0;
            r_inflight <= 1'b0;
            r_in_eol   <= 1'b0;
            r_in_eof   <= 1'b0;
            r_pat      <= 8'h00;
        end else begin
            if (w_start) begin
                r_addr <= '0;
                r_col  <= '0;
                r_row  <= '0;
                r_test <= w_test_in;
            end else if (w_issue) begin
                if (!w_last) r_addr <= r_addr + 1'b1;
                if (r_col == CW'(img_width - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_in_eol <= (r_col == CW'(img_width - 1));
                r_in_eof <= w_last;
                r_pat    <= w_pat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) r_fifo_data[i] <= 8'h00;
            r_fifo_eol <= 2'b00;
            r_fifo_eof <= 2'b00;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_fifo_eol[r_wr_ptr]  <= r_in_eol;
                r_fifo_eof[r_wr_ptr]  <= r_in_eof;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_pixel_streamer.sv
// tb/tb_pixel_streamer.sv - directed self-checking bench for pixel_streamer
module tb_pixel_streamer;
    localparam int N = 16;

    logic       clk = 1'b0;
    logic       reset, start, mem_rd_en, busy, done;
    logic [3:0] mem_addr;
    logic [7:0] mem_data = 8'h00;
    logic [7:0] pixel_out;
    logic       pixel_valid, pixel_ready, pixel_eol, pixel_eof;
    logic       test_mode;

    logic [7:0] mem [N];
    logic [7:0] q_pix [$];
    bit         q_eol [$];
    bit         q_eof [$];
    int         n_vec = 0, n_err = 0, done_cnt = 0, rd_cnt = 0;
    logic       hold_v = 1'b0;
    logic [7:0] hold_p = 8'h00;

    pixel_streamer #(.img_height(4), .img_width(4), .addr_width(4)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef PIXEL_STREAMER_TESTPAT_EN
        .test_mode(test_mode),
`endif
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_data(mem_data), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .pixel_eol(pixel_eol), .pixel_eof(pixel_eof)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < N; i++) mem[i] = 8'h10 + 8'(i);
    always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("hold", {31'd0, pixel_valid} << 8 | {24'd0, pixel_out}, {23'd0, 1'b1, hold_p});
            if (pixel_valid && pixel_ready) begin
                q_pix.push_back(pixel_out);
                q_eol.push_back(pixel_eol);
                q_eof.push_back(pixel_eof);
            end
            if (done) done_cnt++;
            if (mem_rd_en) rd_cnt++;
            hold_v = pixel_valid && !pixel_ready;
            hold_p = pixel_out;
        end
    end

    task automatic start_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic clear_q();
        q_pix.delete(); q_eol.delete(); q_eof.delete();
    endtask

    task automatic check_frame(input bit pat);
        logic [9:0] e;
        chk("npix", q_pix.size(), N);
        for (int i = 0; i < N; i++) begin
            if (i < q_pix.size()) begin
                e = {(i == 15), (i % 4 == 3), pat ? {4'(i / 4), 4'(i % 4)} : 8'h10 + 8'(i)};
                chk("pix", {22'd0, q_eof[i], q_eol[i], q_pix[i]}, {22'd0, e});
            end
        end
        clear_q();
    endtask

    task automatic run_until_done(input bit toggle);
        int base;
        base = done_cnt;
        for (int t = 0; t < 300 && done_cnt == base; t++) begin
            pixel_ready = toggle ? ~pixel_ready : 1'b1;
            @(posedge clk); #1;
        end
        chk("done_seen", done_cnt - base, 1);
        pixel_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt - base, 1);
        chk("idle", {31'd0, busy}, 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pixel_ready = 1'b1; test_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {mem_addr, pixel_out, busy, done, mem_rd_en, pixel_valid, pixel_eol, pixel_eof}, 0);
        reset = 1'b1;

        // Nominal frame: per-cycle control timing relative to the start edge E0
        start_frame();
        for (int k = 0; k <= N + 3; k++) begin
            @(negedge clk);
            chk("ctl", {busy, done, mem_rd_en, pixel_valid},
                {(k <= N + 1), (k == N + 2), (k < N), (k >= 2 && k <= N + 1)});
            if (k < N) chk("addr", mem_addr, k);
        end
        chk("nom_done", done_cnt, 1);
        chk("nom_reads", rd_cnt, N);
        check_frame(1'b0);

        // Backpressure: ready low for 6 cycles after start
        @(posedge clk); #1 pixel_ready = 1'b0; rd_cnt = 0;
        start_frame();
        repeat (6) @(posedge clk);
        #1;
        chk("bp_reads", rd_cnt, 2);
        chk("bp_head", {pixel_valid, pixel_out}, {1'b1, 8'h10});
        run_until_done(1'b0);
        chk("bp_reads_tot", rd_cnt, N);
        check_frame(1'b0);

        // Ready toggling every cycle
        start_frame();
        run_until_done(1'b1);
        check_frame(1'b0);

        // start re-pulsed in FETCH and DRAIN is ignored
        begin
            int base;
            base = done_cnt;
            start_frame();
            for (int k = 1; k <= N + 4; k++) begin
                @(posedge clk); #1;
                start = (k == 3 || k == N + 1);
            end
            start = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("repulse_done", done_cnt - base, 1);
            chk("repulse_idle", {31'd0, busy}, 0);
            check_frame(1'b0);
        end
        start_frame();
        run_until_done(1'b0);
        check_frame(1'b0);

        // Reset after 5 transfers abandons the frame
        start_frame();
        for (int t = 0; t < 100 && q_pix.size() < 5; t++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        chk("rst_mid", {mem_addr, pixel_out, busy, done, mem_rd_en, pixel_valid, pixel_eol, pixel_eof}, 0);
        chk("rst_npix", q_pix.size(), 5);
        begin
            int base;
            base = done_cnt;
            repeat (3) @(posedge clk);
            #1 reset = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            chk("rst_nodone", done_cnt - base, 0);
        end
        clear_q();
        start_frame();
        run_until_done(1'b0);
        check_frame(1'b0);

`ifdef PIXEL_STREAMER_TESTPAT_EN
        rd_cnt = 0;
        test_mode = 1'b1;
        start_frame();
        test_mode = 1'b0;
        run_until_done(1'b0);
        chk("pat_reads", rd_cnt, 0);
        check_frame(1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pixel_streamer.md
Name: pixel_streamer

Overview:
- Upstream feeder for the resizing stage: on start, reads a stored img_height x img_width 8-bit grayscale image from a synchronous-read pixel memory in row-major order.
- Streams the pixels to the resizer over a valid/ready handshake, with end-of-line and end-of-frame tags.
- Absorbs the 1-cycle memory read latency and downstream backpressure in a 2-entry output FIFO.
- Sustains 1 pixel/clk.

Parameters:
- img_height, 4, image rows.
- img_width, 4, image columns.
- addr_width, 4, pixel memory address width; must satisfy 2^addr_width >= img_height*img_width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin streaming one frame; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  1-cycle pulse after the last pixel handshake.
- mem_rd_en  output  1  memory read strobe.
- mem_addr  output  addr_width  read address; data returned on mem_data in the next cycle.
- mem_data  input  8  read data, valid in the cycle after mem_rd_en.
- pixel_out  output  8  pixel to resizer.
- pixel_valid  output  1  pixel_out/tags valid.
- pixel_ready  input  1  resizer accepts the pixel.
- pixel_eol  output  1  current pixel is the last of its row.
- pixel_eof  output  1  current pixel is the last of the frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE; FIFO emptied; in-flight flag cleared; read address counter = 0.
  - All outputs 0.
  - Reset mid-frame abandons the frame; no done pulse.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: start=1 at an edge → FETCH; address counter cleared.
  - FETCH: issue reads (see credit rule). After address N-1 is issued (N = img_height*img_width) → DRAIN.
  - DRAIN: wait until FIFO empty and no read in flight, with the final handshake done. Then pulse done for 1 cycle, busy=0, → IDLE.
  - start is ignored in FETCH and DRAIN; the next frame needs start in IDLE.
- Credit rule (FETCH):
  - mem_rd_en=1 iff credit < 2, where credit = fifo_count + inflight - (pixel_valid & pixel_ready).
  - mem_addr = address counter; the counter increments on each issued read.
  - Guarantees no FIFO overflow.
- Read return:
  - The cycle after mem_rd_en, mem_data is pushed into the FIFO at the clock edge.
  - Each entry carries eol = (col == img_width-1) and eof = (index == N-1), computed from the issued address.
  - Row/col counters wrap col at img_width-1.
- Output:
  - pixel_valid = FIFO not empty.
  - pixel_out, pixel_eol and pixel_eof come from the FIFO head.
  - Transfer on an edge with pixel_valid & pixel_ready.
  - While valid & !ready, all output fields are held stable.
  - Push and pop in the same cycle are legal and leave the count unchanged.
- Timing (ready held 1):
  - start sampled at edge E0.
  - mem_rd_en/addr 0 during cycle E0–E1.
  - pixel_valid first high after E2.
  - Pixels transfer at E3..E(N+2).
  - done high in the cycle after E(N+2), simultaneous with busy falling.
  - mem_rd_en is continuous (one read per cycle) for N cycles.
- Backpressure:
  - With ready held 0, at most 2 reads are issued before mem_rd_en stays 0.
  - No pixel is lost or duplicated.
- mem_addr is held at its last value when mem_rd_en=0; it returns to 0 only on reset or accepted start.

Optional Feature:
- Macro: PIXEL_STREAMER_TESTPAT_EN.
- Defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1 at start, the frame sources pixels from an internal pattern instead of mem_data: pixel = {row[3:0], col[3:0]} (truncated to 8 bits).
  - Timing and handshake are identical (pattern value is registered with the same 1-cycle latency); mem_rd_en stays 0 for that frame.
  - test_mode is latched at start; changes mid-frame are ignored.
- Undefined:
  - No test_mode port; the data path is memory only.

Test Plan:
- Memory holds mem[i]=8'h10+i, ready=1, start pulse → 16 pixels 8'h10..8'h1F in order, valid from E2, eol on indices 3/7/11/15, eof only on index 15, done 1 cycle after E18.
- Ready held 0 for 6 cycles after start → exactly 2 reads issued, pixel_out=8'h10 held stable; ready released → remaining 8'h11..8'h1F with no gap or duplicate.
- Ready toggling 1,0,1,0 over the whole frame → 16 transfers in order, FIFO never overflows, done after the 16th handshake.
- start re-pulsed during FETCH and DRAIN → ignored; single done pulse, 16 pixels only; start in IDLE afterwards → second identical frame.
- reset=0 asserted after 5 pixels transferred → outputs 0 immediately, no done; new start → frame restarts at mem[0].
- PIXEL_STREAMER_TESTPAT_EN with test_mode=1 → pixels 8'h00,01,02,03,10,11,…,33, mem_rd_en never asserted.
